// File: rtl/i2c_reg_ctrl.sv
// Register-write sequencer between the i2c slave byte stream and the LED register file.
// The first byte of each write selects a register; the bytes after it fill registers in order.
module i2c_reg_ctrl #(
  parameter int REG_AW = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        data_i,
  input  logic              data_valid_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  input  logic              busy_i,
  output logic              update_o,
  output logic              err_o,
  output logic [REG_AW-1:0] ptr_o
);

  localparam int                NUM_REGS  = 2 ** REG_AW;
  localparam logic [8:0]        PTR_LIMIT = 9'(NUM_REGS);
  localparam logic [REG_AW-1:0] PTR_MAX   = '1;
  localparam logic [REG_AW-1:0] PTR_ONE   = REG_AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_PTR,
    ST_WRITE,
    ST_DISCARD
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        regs [NUM_REGS];
  logic [REG_AW-1:0] ptr, ptr_nxt;
  logic              dirty, dirty_nxt;
  logic              pending, pending_nxt;
  logic              update_nxt, err_nxt;
  logic              wr_en;
  logic              fire_req, want_update;

  // A byte arriving with a start strobe is dropped; one arriving with a stop is still used.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    err_nxt   = 1'b0;
    wr_en     = 1'b0;

    if (data_valid_i && !start_i) begin
      case (state)
        ST_GET_PTR: begin
          if ({1'b0, data_i} < PTR_LIMIT) begin
            ptr_nxt   = data_i[REG_AW-1:0];
            state_nxt = ST_WRITE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_DISCARD;
          end
        end
        ST_WRITE: begin
          wr_en = 1'b1;
          if (ptr == PTR_MAX) begin
            if (WRAP) ptr_nxt = '0;
            else      state_nxt = ST_DISCARD;
          end else begin
            ptr_nxt = ptr + PTR_ONE;
          end
        end
        default: ;
      endcase
    end

    if (stop_i)       state_nxt = ST_IDLE;
    else if (start_i) state_nxt = ST_GET_PTR;
  end

  // A request that cannot go out right now (driver busy, or a pulse just issued) is parked in
  // pending; later dirty stops merge into it, and it fires once busy_i is seen low.
  always_comb begin
    fire_req    = stop_i && (dirty || wr_en);
    want_update = pending || fire_req;
    update_nxt  = 1'b0;
    pending_nxt = pending;
    dirty_nxt   = dirty || wr_en;

    if (fire_req) dirty_nxt = 1'b0;

    if (want_update) begin
      if (!busy_i && !update_o) begin
        update_nxt  = 1'b1;
        pending_nxt = 1'b0;
      end else begin
        pending_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      dirty    <= 1'b0;
      pending  <= 1'b0;
      update_o <= 1'b0;
      err_o    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      dirty    <= dirty_nxt;
      pending  <= pending_nxt;
      update_o <= update_nxt;
      err_o    <= err_nxt;
      if (wr_en) regs[ptr] <= data_i;
    end
  end

  assign rd_data_o = regs[rd_addr_i];
  assign ptr_o     = ptr;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl: one wrapping and one non-wrapping instance share stimulus,
// and every expected value below is worked out by hand from the intended behaviour.
module tb_i2c_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       data_valid_i = 1'b0;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic [3:0] rd_addr_i = 4'h0;
  logic       busy_i = 1'b0;

  logic [7:0] rd_data_w, rd_data_nw;
  logic       update_w, update_nw;
  logic       err_w, err_nw;
  logic [3:0] ptr_w, ptr_nw;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_regs [16];

  always #5 clk = ~clk;

  i2c_reg_ctrl #(.REG_AW(4), .WRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .data_valid_i(data_valid_i),
    .start_i(start_i), .stop_i(stop_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_w),
    .busy_i(busy_i), .update_o(update_w), .err_o(err_w), .ptr_o(ptr_w)
  );

  i2c_reg_ctrl #(.REG_AW(4), .WRAP(1'b0)) dut_nw (
    .clk(clk), .reset(reset), .data_i(data_i), .data_valid_i(data_valid_i),
    .start_i(start_i), .stop_i(stop_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_nw),
    .busy_i(busy_i), .update_o(update_nw), .err_o(err_nw), .ptr_o(ptr_nw)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Strobes are held across exactly one rising edge; returns 1 ns after that edge.
  task automatic applyStimulus(input logic st, input logic sp, input logic dv, input logic [7:0] d);
    start_i = st;
    stop_i = sp;
    data_valid_i = dv;
    data_i = d;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    stop_i = 1'b0;
    data_valid_i = 1'b0;
    data_i = 8'h00;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleCycle();
    idleCycle();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
  endtask

  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr_i = 4'(i);
      #0.1;
      checkOutput($sformatf("%s_reg%0d", tag, i), 32'(rd_data_w), 32'(exp_regs[i]));
    end
  endtask

  task automatic readReg(input int addr);
    rd_addr_i = 4'(addr);
    #0.1;
  endtask

  int hi_count;

  initial begin
    $display("[TB] i2c_reg_ctrl directed test");
    doReset();
    checkOutput("rst_ptr", 32'(ptr_w), 32'h0);
    checkOutput("rst_update", 32'(update_w), 32'h0);
    checkOutput("rst_err", 32'(err_w), 32'h0);
    checkAllRegs("rst");

    // Basic write: pointer 1, two data bytes, dirty stop with driver idle
    busy_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h71);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hA8);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("basic_update_pulse", 32'(update_w), 32'h1);
    idleCycle();
    checkOutput("basic_update_single", 32'(update_w), 32'h0);
    checkOutput("basic_ptr", 32'(ptr_w), 32'h3);
    exp_regs[1] = 8'h71;
    exp_regs[2] = 8'hA8;
    checkAllRegs("basic");

    // Out-of-range pointer byte
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hA8);
    checkOutput("oor_err_pulse", 32'(err_w), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h55);
    checkOutput("oor_err_single", 32'(err_w), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("oor_no_update", 32'(update_w), 32'h0);
    idleCycle();
    checkOutput("oor_no_update2", 32'(update_w), 32'h0);
    checkOutput("oor_ptr", 32'(ptr_w), 32'h3);
    checkAllRegs("oor");

    // Wrap-around on both instances
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h0F);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h22);
    checkOutput("nowrap_ptr_held", 32'(ptr_nw), 32'hF);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("wrap_update", 32'(update_w), 32'h1);
    checkOutput("nowrap_update", 32'(update_nw), 32'h1);
    checkOutput("wrap_ptr", 32'(ptr_w), 32'h1);
    readReg(15);
    checkOutput("wrap_reg15", 32'(rd_data_w), 32'h11);
    checkOutput("nowrap_reg15", 32'(rd_data_nw), 32'h11);
    readReg(0);
    checkOutput("wrap_reg0", 32'(rd_data_w), 32'h22);
    checkOutput("nowrap_reg0", 32'(rd_data_nw), 32'h00);
    readReg(1);
    checkOutput("wrap_reg1", 32'(rd_data_w), 32'h00);

    // Busy hold-off: one request held for 20 busy cycles
    doReset();
    busy_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h04);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    hi_count = (update_w === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      idleCycle();
      if (update_w === 1'b1) hi_count++;
    end
    checkOutput("busy_hold_quiet", 32'(hi_count), 32'h0);
    busy_i = 1'b0;
    idleCycle();
    checkOutput("busy_release_pulse", 32'(update_w), 32'h1);
    idleCycle();
    checkOutput("busy_release_single", 32'(update_w), 32'h0);

    // Two dirty transactions while busy merge into one pulse
    busy_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h06);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h07);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h22);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    hi_count = (update_w === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      idleCycle();
      if (update_w === 1'b1) hi_count++;
    end
    checkOutput("merge_busy_quiet", 32'(hi_count), 32'h0);
    busy_i = 1'b0;
    hi_count = 0;
    for (int i = 0; i < 6; i++) begin
      idleCycle();
      if (update_w === 1'b1) hi_count++;
    end
    checkOutput("merge_one_pulse", 32'(hi_count), 32'h1);
    exp_regs[4] = 8'h5A;
    exp_regs[6] = 8'h11;
    exp_regs[7] = 8'h22;
    checkAllRegs("busy");

    // Collisions: start with a byte drops it; stop with a byte writes it
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h05);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h33);
    checkOutput("coll_start_ptr", 32'(ptr_w), 32'h5);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h05);
    readReg(5);
    checkOutput("coll_start_dropped", 32'(rd_data_w), 32'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h44);
    checkOutput("coll_stop_update", 32'(update_w), 32'h1);
    checkOutput("coll_stop_ptr", 32'(ptr_w), 32'h6);
    idleCycle();
    checkOutput("coll_stop_single", 32'(update_w), 32'h0);
    exp_regs[5] = 8'h44;
    checkAllRegs("coll");

    // Reset mid-transaction
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h03);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h99);
    readReg(3);
    checkOutput("midrst_written", 32'(rd_data_w), 32'h99);
    doReset();
    hi_count = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h02);
    if (update_w === 1'b1) hi_count++;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h77);
    if (update_w === 1'b1) hi_count++;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    if (update_w === 1'b1) hi_count++;
    idleCycle();
    if (update_w === 1'b1) hi_count++;
    checkOutput("midrst_no_update", 32'(hi_count), 32'h0);
    checkOutput("midrst_ptr", 32'(ptr_w), 32'h0);
    checkAllRegs("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
